// File: rtl/instruction_memory_loader.sv
// Streams 32-bit instruction words into a byte-wide memory write port,
// little-endian, one byte per cycle, starting at BASE_ADDR.
module instruction_memory_loader #(
  parameter int                    SIZE       = 256,
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [31:0]               in_word,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic                      mem_wr_en,
  output logic [ADDR_WIDTH-1:0]     mem_wr_addr,
  output logic [7:0]                mem_wr_data,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [$clog2(SIZE/4):0]   word_count
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, ERROR} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q;
  logic [1:0]              byte_idx_q;
  logic [31:0]             word_q;
  logic                    last_q;
  logic                    done_q;
  logic [$clog2(SIZE/4):0] count_q;

  // One extra bit keeps the fit check honest even when ptr is near the top of its range.
  logic [ADDR_WIDTH:0] ptr_end;
  logic                fits;
  logic                handshake;

  assign ptr_end   = {1'b0, ptr_q} + (ADDR_WIDTH+1)'(4);
  assign fits      = (ptr_end <= (ADDR_WIDTH+1)'(SIZE));
  assign handshake = in_valid & in_ready;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        if (!fits) begin
          state_d = ERROR;
        end else begin
          in_ready = 1'b1;
          if (in_valid) state_d = WRITE;
        end
      end
      WRITE: begin
        if (byte_idx_q == 2'd3) state_d = last_q ? IDLE : LOAD;
      end
      ERROR: begin
        if (start) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q == LOAD) || (state_q == WRITE);
  assign error       = (state_q == ERROR);
  assign mem_wr_en   = (state_q == WRITE);
  assign mem_wr_addr = mem_wr_en ? (ptr_q + ADDR_WIDTH'(byte_idx_q)) : '0;
  assign mem_wr_data = mem_wr_en ? word_q[{byte_idx_q, 3'b000} +: 8] : 8'h00;
  assign done        = done_q;
  assign word_count  = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= BASE_ADDR;
      byte_idx_q <= 2'd0;
      word_q     <= 32'h0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE, ERROR: begin
          if (start) begin
            ptr_q   <= BASE_ADDR;
            count_q <= '0;
          end
        end
        LOAD: begin
          if (handshake) begin
            word_q     <= in_word;
            last_q     <= in_last;
            byte_idx_q <= 2'd0;
          end
        end
        WRITE: begin
          byte_idx_q <= byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            ptr_q   <= ptr_q + ADDR_WIDTH'(4);
            count_q <= count_q + 1'b1;
            done_q  <= last_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
